// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock, WIDTH steps per product.
// Optional `define BOOTH_ABORT_EN adds an `abort` input that cancels an in-flight operation.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef BOOTH_ABORT_EN
    input  logic                 abort,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 q1,
    output logic                 q0,
    input  logic [1:0]           q1q0,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           dbg_state
);

    // Handshake: start is a request sampled only in IDLE (never queued); done pulses
    // for one cycle when product is valid, and product holds until the next completion.

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       sum_t;
    logic                 abort_req;

`ifdef BOOTH_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        sum_t     = a_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    count_d = CW'(WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Unexpected decoder codes fall through to shift-only.
                case (q1q0)
                    2'b01:   sum_t = a_q + m_q;
                    2'b10:   sum_t = a_q - m_q;
                    default: sum_t = a_q;
                endcase
                a_d     = {sum_t[WIDTH], sum_t[WIDTH:1]};
                q_d     = {sum_t[0], q_q[WIDTH-1:1]};
                qm1_d   = q_q[0];
                count_d = count_q - CW'(1);
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (count_q == CW'(1)) begin
                    product_d = {a_d[WIDTH-1:0], q_d};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    assign q1        = q_q[0];
    assign q0        = qm1_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: signed-product/timing model plus directed vectors.
module tb_booth_seq_multiplier;
    localparam int W  = 32;
    localparam int PW = 2 * W;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic [W-1:0]  mcand  = '0;
    logic [W-1:0]  mplier = '0;
    logic          q1, q0;
    logic [1:0]    q1q0;
    logic          busy, done;
    logic [PW-1:0] product;
    logic [1:0]    dbg_state;
    logic          abort_now;
`ifdef BOOTH_ABORT_EN
    logic          abort = 1'b0;
    assign abort_now = abort;
`else
    assign abort_now = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // External Booth decoder: code mirrors the pair.
    assign q1q0 = {q1, q0};

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
`ifdef BOOTH_ABORT_EN
        .abort        (abort),
`endif
        .multiplicand (mcand),
        .multiplier   (mplier),
        .q1           (q1),
        .q0           (q0),
        .q1q0         (q1q0),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] x, y;
        x = $signed({{W{a[W-1]}}, a});
        y = $signed({{W{b[W-1]}}, b});
        return x * y;
    endfunction

    logic          mdl_busy, mdl_done;
    logic [PW-1:0] mdl_prod, mdl_pend;
    int            mdl_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy <= 1'b0;
            mdl_done <= 1'b0;
            mdl_prod <= '0;
            mdl_pend <= '0;
            mdl_left <= 0;
        end else begin
            mdl_done <= 1'b0;
            if (mdl_busy) begin
                if (abort_now) begin
                    mdl_busy <= 1'b0;
                    mdl_left <= 0;
                end else if (mdl_left == 1) begin
                    mdl_busy <= 1'b0;
                    mdl_done <= 1'b1;
                    mdl_prod <= mdl_pend;
                    mdl_left <= 0;
                end else begin
                    mdl_left <= mdl_left - 1;
                end
            end else if (!mdl_done && start) begin
                mdl_busy <= 1'b1;
                mdl_left <= W;
                mdl_pend <= ref_mul(mcand, mplier);
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_busy", {63'd0, busy}, {63'd0, mdl_busy});
            chk("cyc_done", {63'd0, done}, {63'd0, mdl_done});
            chk("cyc_product", product, mdl_prod);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [PW-1:0] exp_p);
        int cyc;
        int busy_cnt;
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) busy_cnt++;
        end while (!done && cyc < 200);
        chk({name, "_done_seen"}, {63'd0, done}, 64'd1);
        chk({name, "_latency"}, PW'(cyc), PW'(W + 1));
        chk({name, "_busy_cycles"}, PW'(busy_cnt), PW'(W));
        chk({name, "_product"}, product, exp_p);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int done_cnt;

        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_product", product, 64'd0);
        chk("reset_q1", {63'd0, q1}, 64'd0);
        chk("reset_q0", {63'd0, q0}, 64'd0);
        chk("reset_state", {62'd0, dbg_state}, 64'd0);

        // Hand-computed pins on the model itself.
        chk("model_3x-5", ref_mul(32'd3, 32'hFFFF_FFFB), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model_min_sq", ref_mul(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        chk("model_7x6", ref_mul(32'd7, 32'd6), 64'd42);

        rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        run_op("m3_q-5",  32'd3,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("min_sq",  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("max_sq",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        run_op("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        run_op("neg1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        run_op("min_x1",  32'd1,         32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
        run_op("zero",    32'd0,         32'h1234_5678, 64'd0);

        // Start held high; operands change mid-run and must not disturb the first result.
        mcand  = 32'd5;
        mplier = 32'd9;
        start  = 1'b1;
        cyc    = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                mcand  = 32'hFFFF_FFFC;
                mplier = 32'd11;
            end
        end while (!done && cyc < 200);
        chk("held_first_latency", PW'(cyc), PW'(W + 1));
        chk("held_first_product", product, 64'd45);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 200);
        chk("held_second_gap", PW'(cyc), PW'(W + 2));
        chk("held_second_product", product, 64'hFFFF_FFFF_FFFF_FFD4);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        mcand  = 32'd100;
        mplier = 32'd200;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_done", {63'd0, done}, 64'd0);
        chk("async_rst_product", product, 64'd0);
        chk("async_rst_q1", {63'd0, q1}, 64'd0);
        chk("async_rst_q0", {63'd0, q0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (busy || done) done_cnt++;
        end
        chk("post_reset_idle", PW'(done_cnt), 64'd0);
        run_op("m7_q6", 32'd7, 32'd6, 64'd42);

`ifdef BOOTH_ABORT_EN
        // Abort in CALC: busy drops next cycle, no done, product keeps 42.
        mcand  = 32'd9;
        mplier = 32'd9;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_drop", {63'd0, busy}, 64'd0);
        done_cnt = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", PW'(done_cnt), 64'd0);
        chk("abort_product_kept", product, 64'd42);
`endif

        repeat (3) @(negedge clk);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
